controlador_de_interrupcoes: RTL and testbench
==============================================

# controlador_de_interrupcoes

Parametrised interrupt controller sitting between the I/O/disk request lines and the processor control unit. It latches up to NUM_SRC edge-triggered requests plus an optional preemption timer, masks and prioritises them, and raises a one-cycle take pulse with an interrupt code only at an instruction boundary while the CPU is in user mode. It holds the request in service until the kernel acknowledges it.

## Interface
Parameters:
- NUM_SRC, 8: number of external request lines; index 0 has the highest priority.
- CODE_W, 32: width of the interrupt code output.
- QUANTUM_W, 16: width of the preemption quantum.
- ID_W, $clog2(NUM_SRC+1): width of the source ID; derived, not overridable.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  NUM_SRC  request lines; a rising edge sets the matching pending bit.
- mode  in  1  1 = user mode, 0 = kernel mode.
- instrDone  in  1  instruction boundary strobe; the control unit may be redirected this cycle.
- maskWrite  in  1  loads the mask register from maskData.
- maskData  in  NUM_SRC  enable mask; 1 = enabled.
- ackWrite  in  1  kernel acknowledge strobe.
- ackId  in  ID_W  source being acknowledged; value NUM_SRC is the timer.
- quantumWrite  in  1  loads the quantum register from quantumData.
- quantumData  in  QUANTUM_W  instructions per time slice; 0 disables the timer.
- intTake  out  1  one-cycle pulse; the control unit saves the PC and switches to kernel mode.
- intc  out  CODE_W  code of the interrupt in service = ID+1, zero-extended; 0 = none.
- pending  out  NUM_SRC+1  pending bits; bit NUM_SRC is the timer.
- busy  out  1  high in states TAKE and SERVICE.

## Operation
Edge detection and pending bits:
- irq_q registers irq.
- pending[i] is set when irq[i] & ~irq_q[i].
- pending[i] is cleared by ackWrite with ackId==i.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- ackId values above NUM_SRC are ignored.

Eligibility and priority:
- eligible = pending & {timer enable bit, mask}.
- The winner is the lowest eligible index.

State machine states: IDLE, WAIT, TAKE, SERVICE.
- IDLE → WAIT when mode & |eligible.
- WAIT → TAKE when instrDone & mode & |eligible. The winner ID is latched into intc on this edge.
- WAIT → IDLE when ~mode or ~|eligible.
- TAKE → SERVICE unconditionally. intTake=1 only in TAKE.
- SERVICE → IDLE on ackWrite with ackId equal to the latched ID. intc clears to 0 on this edge.
- An ack for any other ID only clears that pending bit.
- Requests arriving during TAKE or SERVICE stay pending; there is no nesting.

Mask writes apply from the next cycle and never abort TAKE or SERVICE.

Reset values:
- state IDLE.
- pending, irq_q, mask, intc, quantum register and counter all 0.
- intTake=0, busy=0.
- Assertion mid-operation drops any in-service interrupt immediately, with no pulse.

## Timing
- irq rises, sampled at edge n: pending visible after edge n.
- WAIT after edge n+1.
- With instrDone high in that cycle: TAKE after edge n+2, so intTake is high during cycle n+2..n+3, and intc is valid from the same edge.
- SERVICE after edge n+3.
- Minimum request-to-take latency is 3 cycles. A missing boundary stretches WAIT indefinitely.
- ack to IDLE takes 1 cycle. A still-eligible request can re-enter WAIT on the following edge.

## Configuration
- CONTROLADOR_TIMER_EN defined:
  - A QUANTUM_W down-counter loads from the quantum register on quantumWrite and on reaching zero.
  - It decrements on instrDone & mode while in IDLE or WAIT.
  - Its 1→0 transition sets pending[NUM_SRC].
  - The timer is enabled iff the quantum register ≠ 0.
- Undefined:
  - No counter is built.
  - pending[NUM_SRC] is constant 0.
  - quantumWrite and quantumData are ignored; the ports remain.

## Structure
- The shared package izero_pkg holds:
  - the state encoding constants (IDLE=0, WAIT=1, TAKE=2, SERVICE=3),
  - the ID-width function,
  - the code-offset constant INTC_OFFSET=1.
- One sub-module, codificador_de_prioridade, is parametrised by width. It produces the lowest-index ID and a valid flag.

## Test plan
- mask=8'hFF, mode=1, instrDone held 1, irq[3] rises → intTake pulse 3 cycles later, intc=4, busy=1 until ackWrite/ackId=3, then intc=0.
- irq[5] and irq[2] rise together, mask=8'hFF → intc=3 first; after ack 2, intc=6 is taken next.
- mode=0 with pending[1] set → no intTake; set mode=1 with instrDone → take within 2 cycles, intc=2.
- irq[4] rises with mask bit 4 = 0 → pending[4]=1 and no take; write mask bit 4 = 1 → take follows, intc=5.
- With CONTROLADOR_TIMER_EN, quantum=3, mode=1, instrDone every cycle → pending[8]=1 after 3 boundaries, intc=9; with quantum=0 → never.
- rst asserted during SERVICE → intc=0, busy=0, pending=0 immediately; no intTake after release.

Source files
------------

// File: rtl/izero_pkg.sv
// izero_pkg: definitions shared by the interrupt controller and its sub-module.
//   state_e     - controller state encoding (IDLE=0, WAIT=1, TAKE=2, SERVICE=3)
//   INTC_OFFSET - added to a source ID to form the interrupt code (code 0 = none)
//   id_width()  - width of a source ID for a given number of external sources
//                 (one extra ID is reserved for the preemption timer)
package izero_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    TAKE    = 2'd2,
    SERVICE = 2'd3
  } state_e;

  localparam int INTC_OFFSET = 1;

  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/codificador_de_prioridade.sv
// codificador_de_prioridade: lowest-index-wins priority encoder.
//   req_i   [WIDTH-1:0] request vector, bit 0 has the highest priority
//   id_o    [ID_W-1:0]  index of the lowest set bit (0 when none)
//   valid_o             at least one request bit is set
module codificador_de_prioridade #(
  parameter int WIDTH = 9,
  parameter int ID_W  = 4
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_de_interrupcoes.sv
// controlador_de_interrupcoes: interrupt controller between the I/O request
// lines and the processor control unit. Edge-detects NUM_SRC requests into
// pending bits, masks and prioritises them (index 0 highest, timer lowest),
// and issues a one-cycle take pulse at an instruction boundary in user mode.
// The request stays in service until the kernel acknowledges its ID.
//
// Optional feature: define CONTROLADOR_TIMER_EN to build the preemption timer
// (pending bit NUM_SRC). Without it the quantum ports are accepted but unused.
//
// Ports:
//   clock, rst          clock; asynchronous active-low reset
//   irq                 request lines, rising edge sets pending
//   mode                1 = user mode, 0 = kernel mode
//   instrDone           instruction boundary strobe
//   maskWrite/maskData  load the enable mask (1 = enabled)
//   ackWrite/ackId      kernel acknowledge; ackId == NUM_SRC is the timer
//   quantumWrite/Data   load the preemption quantum (0 disables the timer)
//   intTake             one-cycle take pulse
//   intc                code of the interrupt in service (ID+1), 0 = none
//   pending             pending bits, bit NUM_SRC is the timer
//   busy                high while taking or servicing an interrupt
module controlador_de_interrupcoes
  import izero_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int CODE_W    = 32,
  parameter int QUANTUM_W = 16
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            irq,
  input  logic                          mode,
  input  logic                          instrDone,
  input  logic                          maskWrite,
  input  logic [NUM_SRC-1:0]            maskData,
  input  logic                          ackWrite,
  input  logic [id_width(NUM_SRC)-1:0]  ackId,
  input  logic                          quantumWrite,
  input  logic [QUANTUM_W-1:0]          quantumData,
  output logic                          intTake,
  output logic [CODE_W-1:0]             intc,
  output logic [NUM_SRC:0]              pending,
  output logic                          busy
);

  localparam int ID_W = id_width(NUM_SRC);
  localparam int NP   = NUM_SRC + 1;

  logic [NUM_SRC-1:0] irq_q, mask_q;
  logic [NP-1:0]      pending_q, pending_d, clr, eligible;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d, win_id;
  logic               win_vld, timer_en, timer_fire, count_en;

  // Ack decode; IDs above NUM_SRC match no bit and are dropped.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NP; i++) begin
      if (ackWrite && ackId == ID_W'(i)) clr[i] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so a simultaneous edge survives its ack.
  assign pending_d = (pending_q & ~clr) | {timer_fire, irq & ~irq_q};
  assign eligible  = pending_q & {timer_en, mask_q};

  codificador_de_prioridade #(
    .WIDTH (NP),
    .ID_W  (ID_W)
  ) u_prio (
    .req_i   (eligible),
    .id_o    (win_id),
    .valid_o (win_vld)
  );

  // Time slice only advances while user code is actually running.
  assign count_en = instrDone & mode & ((state_q == IDLE) || (state_q == WAIT));

`ifdef CONTROLADOR_TIMER_EN
  logic [QUANTUM_W-1:0] quantum_q, cnt_q, cnt_d;

  assign timer_en   = |quantum_q;
  assign timer_fire = !quantumWrite && count_en && timer_en && (cnt_q == QUANTUM_W'(1));

  // Reload instead of sitting at zero, so the next slice starts immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (quantumWrite)
      cnt_d = quantumData;
    else if (count_en && timer_en)
      cnt_d = (cnt_q <= QUANTUM_W'(1)) ? quantum_q : cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      quantum_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (quantumWrite) quantum_q <= quantumData;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_quantum;
  assign unused_quantum = ^{quantumWrite, quantumData, count_en};
  assign timer_en       = 1'b0;
  assign timer_fire     = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      irq_q     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      if (maskWrite) mask_q <= maskData;
    end
  end

  // Next-state logic; the winner ID is captured on the WAIT->TAKE edge.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE:    if (mode && win_vld) state_d = WAIT;
      WAIT: begin
        if (!(mode && win_vld)) begin
          state_d = IDLE;
        end else if (instrDone) begin
          state_d = TAKE;
          id_d    = win_id;
        end
      end
      TAKE:    state_d = SERVICE;
      SERVICE: if (ackWrite && ackId == id_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; intc reads zero whenever nothing is in service.
  always_comb begin
    intTake = (state_q == TAKE);
    busy    = (state_q == TAKE) || (state_q == SERVICE);
    intc    = busy ? CODE_W'(id_q) + CODE_W'(INTC_OFFSET) : '0;
    pending = pending_q;
  end

endmodule

// File: tb/tb_controlador_de_interrupcoes.sv
`timescale 1ns/1ps
module tb_controlador_de_interrupcoes;

  localparam int NUM_SRC   = 8;
  localparam int CODE_W    = 32;
  localparam int QUANTUM_W = 16;
  localparam int ID_W      = $clog2(NUM_SRC + 1);

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NUM_SRC-1:0]   irq;
  logic                 mode, instrDone, maskWrite, ackWrite, quantumWrite;
  logic [NUM_SRC-1:0]   maskData;
  logic [ID_W-1:0]      ackId;
  logic [QUANTUM_W-1:0] quantumData;
  logic                 intTake, busy;
  logic [CODE_W-1:0]    intc;
  logic [NUM_SRC:0]     pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [NUM_SRC:0]   m_pend;
  logic [NUM_SRC-1:0] m_mask, m_irq_prev;
  int                 m_svc;
  bit                 m_take, m_armed;
  int                 m_quant, m_cnt;

  controlador_de_interrupcoes #(
    .NUM_SRC(NUM_SRC), .CODE_W(CODE_W), .QUANTUM_W(QUANTUM_W)
  ) dut (
    .clock(clock), .rst(rst), .irq(irq), .mode(mode), .instrDone(instrDone),
    .maskWrite(maskWrite), .maskData(maskData), .ackWrite(ackWrite), .ackId(ackId),
    .quantumWrite(quantumWrite), .quantumData(quantumData),
    .intTake(intTake), .intc(intc), .pending(pending), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    irq = '0; mode = 1'b1; instrDone = 1'b1; maskWrite = 1'b0; maskData = '0;
    ackWrite = 1'b0; ackId = '0; quantumWrite = 1'b0; quantumData = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    maskWrite = 1'b1; maskData = m;
    tick();
    maskWrite = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({intTake, busy, intc, pending} !== '0) begin
      n_bad++;
      $display("FAIL reset_state intTake=%0b busy=%0b intc=%0d pending=%h required all 0",
               intTake, busy, intc, pending);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    write_mask(8'hFF);
    irq[3] = 1'b1;
    tick();
    n_cmp++;
    if (pending !== 9'h008 || intTake !== 1'b0) begin
      n_bad++; $display("FAIL basic_pending pending=%h intTake=%0b required 008/0", pending, intTake);
    end
    tick();
    n_cmp++;
    if (intTake !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_wait intTake=%0b busy=%0b required 0/0", intTake, busy);
    end
    tick();
    n_cmp++;
    if ({intTake, busy, intc} !== {1'b1, 1'b1, 32'd4}) begin
      n_bad++; $display("FAIL basic_take intTake=%0b busy=%0b intc=%0d required 1/1/4", intTake, busy, intc);
    end
    tick();
    n_cmp++;
    if ({intTake, busy, intc} !== {1'b0, 1'b1, 32'd4}) begin
      n_bad++; $display("FAIL basic_service intTake=%0b busy=%0b intc=%0d required 0/1/4", intTake, busy, intc);
    end
    ackWrite = 1'b1; ackId = 4'd3;
    tick();
    ackWrite = 1'b0;
    n_cmp++;
    if ({busy, intc, pending} !== {1'b0, 32'd0, 9'h000}) begin
      n_bad++; $display("FAIL basic_ack busy=%0b intc=%0d pending=%h required 0/0/000", busy, intc, pending);
    end
    irq = '0;
    tick();
  endtask

  task automatic test_two();
    irq = 8'b0010_0100;
    tick(); tick(); tick();
    n_cmp++;
    if ({intTake, intc} !== {1'b1, 32'd3}) begin
      n_bad++; $display("FAIL two_first intTake=%0b intc=%0d required 1/3", intTake, intc);
    end
    tick();
    ackWrite = 1'b1; ackId = 4'd2;
    tick();
    ackWrite = 1'b0;
    n_cmp++;
    if ({busy, intc, pending} !== {1'b0, 32'd0, 9'h020}) begin
      n_bad++; $display("FAIL two_ack busy=%0b intc=%0d pending=%h required 0/0/020", busy, intc, pending);
    end
    tick(); tick();
    n_cmp++;
    if ({intTake, intc} !== {1'b1, 32'd6}) begin
      n_bad++; $display("FAIL two_second intTake=%0b intc=%0d required 1/6", intTake, intc);
    end
    tick();
    ackWrite = 1'b1; ackId = 4'd5;
    tick();
    ackWrite = 1'b0; irq = '0;
    tick();
  endtask

  task automatic test_mode();
    mode = 1'b0;
    irq[1] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (intTake !== 1'b0 || busy !== 1'b0 || pending !== 9'h002) begin
        n_bad++; $display("FAIL mode_kernel intTake=%0b busy=%0b pending=%h required 0/0/002", intTake, busy, pending);
      end
    end
    mode = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({intTake, intc} !== {1'b1, 32'd2}) begin
      n_bad++; $display("FAIL mode_user_take intTake=%0b intc=%0d required 1/2", intTake, intc);
    end
    tick();
    ackWrite = 1'b1; ackId = 4'd1;
    tick();
    ackWrite = 1'b0; irq = '0;
    tick();
  endtask

  task automatic test_mask();
    write_mask(8'hEF);
    irq[4] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || pending !== 9'h010) begin
        n_bad++; $display("FAIL mask_blocked busy=%0b pending=%h required 0/010", busy, pending);
      end
    end
    write_mask(8'hFF);
    tick(); tick();
    n_cmp++;
    if ({intTake, intc} !== {1'b1, 32'd5}) begin
      n_bad++; $display("FAIL mask_take intTake=%0b intc=%0d required 1/5", intTake, intc);
    end
    tick();
    ackWrite = 1'b1; ackId = 4'd4;
    tick();
    ackWrite = 1'b0; irq = '0;
    tick();
  endtask

  task automatic test_timer();
    quantumWrite = 1'b1; quantumData = 16'd3;
    tick();
    quantumWrite = 1'b0;
`ifdef CONTROLADOR_TIMER_EN
    tick(); tick();
    n_cmp++;
    if (pending[NUM_SRC] !== 1'b0) begin
      n_bad++; $display("FAIL timer_early pending8=%0b required 0", pending[NUM_SRC]);
    end
    tick();
    n_cmp++;
    if (pending[NUM_SRC] !== 1'b1) begin
      n_bad++; $display("FAIL timer_fire pending8=%0b required 1", pending[NUM_SRC]);
    end
    tick(); tick();
    n_cmp++;
    if ({intTake, intc} !== {1'b1, 32'd9}) begin
      n_bad++; $display("FAIL timer_take intTake=%0b intc=%0d required 1/9", intTake, intc);
    end
    tick();
    ackWrite = 1'b1; ackId = 4'd8;
    tick();
    ackWrite = 1'b0;
    quantumWrite = 1'b1; quantumData = 16'd0;
    tick();
    quantumWrite = 1'b0;
`endif
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (pending[NUM_SRC] !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL timer_off pending8=%0b busy=%0b required 0/0", pending[NUM_SRC], busy);
      end
    end
  endtask

  task automatic test_reset_service();
    irq[0] = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if ({busy, intc} !== {1'b1, 32'd1}) begin
      n_bad++; $display("FAIL rsvc_pre busy=%0b intc=%0d required 1/1", busy, intc);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({intTake, busy, intc, pending} !== '0) begin
      n_bad++; $display("FAIL rsvc_async intTake=%0b busy=%0b intc=%0d pending=%h required all 0",
                        intTake, busy, intc, pending);
    end
    irq = '0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (intTake !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rsvc_after intTake=%0b busy=%0b required 0/0", intTake, busy);
      end
    end
  endtask

  task automatic test_random();
    bit any, fire, exp_busy;
    int win;
    logic [CODE_W-1:0] exp_intc;
    do_reset();
    m_pend = '0; m_mask = '0; m_irq_prev = '0; m_svc = -1;
    m_take = 1'b0; m_armed = 1'b0; m_quant = 0; m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_SRC; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      mode         = ($urandom_range(9) != 0);
      instrDone    = 1'($urandom_range(1));
      maskWrite    = ($urandom_range(15) == 0);
      maskData     = NUM_SRC'($urandom);
      ackWrite     = ($urandom_range(3) == 0);
      ackId        = (m_svc >= 0 && $urandom_range(1) == 1) ? ID_W'(m_svc) : ID_W'($urandom_range(15));
      quantumWrite = ($urandom_range(63) == 0);
      quantumData  = QUANTUM_W'($urandom_range(6));
      // Highest-priority enabled request, timer last
      any = 1'b0; win = 0;
      for (int i = NUM_SRC; i >= 0; i--)
        if (m_pend[i] && ((i == NUM_SRC) ? (m_quant != 0) : (m_mask[i] == 1'b1))) begin
          any = 1'b1; win = i;
        end
      fire = 1'b0;
`ifdef CONTROLADOR_TIMER_EN
      if (quantumWrite) begin
        m_quant = int'(quantumData); m_cnt = int'(quantumData);
      end else if (m_quant != 0 && instrDone && mode && !m_take && m_svc < 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin fire = 1'b1; m_cnt = m_quant; end
      end
`endif
      for (int i = 0; i <= NUM_SRC; i++) begin
        if (ackWrite && int'(ackId) == i) m_pend[i] = 1'b0;
        if (i < NUM_SRC && irq[i] && !m_irq_prev[i]) m_pend[i] = 1'b1;
      end
      if (fire) m_pend[NUM_SRC] = 1'b1;
      if (m_take) m_take = 1'b0;
      else if (m_svc >= 0) begin
        if (ackWrite && int'(ackId) == m_svc) m_svc = -1;
      end else if (m_armed) begin
        if (!(mode && any)) m_armed = 1'b0;
        else if (instrDone) begin m_armed = 1'b0; m_take = 1'b1; m_svc = win; end
      end else if (mode && any) m_armed = 1'b1;
      if (maskWrite) m_mask = maskData;
      m_irq_prev = irq;
      tick();
      exp_busy = m_take || (m_svc >= 0);
      exp_intc = exp_busy ? CODE_W'(m_svc + 1) : '0;
      n_cmp++;
      if (intTake !== m_take || busy !== exp_busy || intc !== exp_intc || pending !== m_pend) begin
        n_bad++;
        $display("FAIL random_cycle%0d intTake=%0b busy=%0b intc=%0d pending=%h required %0b/%0b/%0d/%h",
                 c, intTake, busy, intc, pending, m_take, exp_busy, exp_intc, m_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two();
    test_mode();
    test_mask();
    test_timer();
    test_reset_service();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
